// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII hex-dump debug path: ASCII constants,
// hexdump FSM encoding and the nibble-to-ASCII helper.
package rgmii_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    typedef enum logic [9:0] {
        IDLE      = 10'b00_0000_0001,
        LOAD      = 10'b00_0000_0010,
        HI_ISSUE  = 10'b00_0000_0100,
        HI_WAIT   = 10'b00_0000_1000,
        LO_ISSUE  = 10'b00_0001_0000,
        LO_WAIT   = 10'b00_0010_0000,
        SEP_ISSUE = 10'b00_0100_0000,
        SEP_WAIT  = 10'b00_1000_0000,
        LF_ISSUE  = 10'b01_0000_0000,
        LF_WAIT   = 10'b10_0000_0000
    } hexdump_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASC_0 + {4'd0, nib};
        else
            return ASC_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data. A pop frees its slot before a
// same-cycle push is qualified, so a full FIFO still accepts a push on a pop.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Head entry trails a fresh write by one cycle; the consumer never
            // samples it sooner than that.
            dout <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rgmii_hexdump.sv
// Buffers RGMII receive bytes and renders them as ASCII hex lines on the
// uart_tx byte/strobe interface, one character per tx_dv.
module rgmii_hexdump
    import rgmii_pkg::*;
#(
    parameter int FIFO_DEPTH     = 64,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [7:0]                     in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic                           tx_dv,
    output logic [7:0]                     tx_byte,
    input  logic                           tx_active,
    input  logic                           tx_done,
    output logic                           overflow,
    output logic [15:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    hexdump_state_t state;
    logic [8:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic [7:0]     cur_byte;
    logic           cur_last;
    logic [7:0]     col;
    logic           crlf;

    assign pop      = (state == LOAD);
    assign in_ready = !fifo_full;

    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .din   ({in_last, in_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= in_valid && fifo_full && !pop;
            if (in_valid && fifo_full && !pop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Each ISSUE state raises tx_dv for one cycle once uart_tx is idle, then
    // moves to WAIT on the following cycle. LOAD pre-issues the high nibble so
    // the first character leaves two cycles after the push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
            cur_byte <= 8'h00;
            cur_last <= 1'b0;
            col      <= 8'd0;
            crlf     <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            unique case (state)
                IDLE: if (!fifo_empty) state <= LOAD;
                LOAD: begin
                    cur_byte <= fifo_dout[7:0];
                    cur_last <= fifo_dout[8];
                    state    <= HI_ISSUE;
                    if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= hex_ascii(fifo_dout[7:4]);
                    end
                end
                HI_ISSUE: begin
                    if (tx_dv) state <= HI_WAIT;
                    else if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= hex_ascii(cur_byte[7:4]);
                    end
                end
                HI_WAIT: if (tx_done) state <= LO_ISSUE;
                LO_ISSUE: begin
                    if (tx_dv) state <= LO_WAIT;
                    else if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= hex_ascii(cur_byte[3:0]);
                    end
                end
                LO_WAIT: if (tx_done) state <= SEP_ISSUE;
                SEP_ISSUE: begin
                    if (tx_dv) state <= SEP_WAIT;
                    else if (!tx_active) begin
                        tx_dv <= 1'b1;
                        if (cur_last || col == 8'(BYTES_PER_LINE - 1)) begin
                            tx_byte <= ASC_CR;
                            col     <= 8'd0;
                            crlf    <= 1'b1;
                        end else begin
                            tx_byte <= ASC_SP;
                            col     <= col + 8'd1;
                            crlf    <= 1'b0;
                        end
                    end
                end
                SEP_WAIT: if (tx_done) state <= crlf ? LF_ISSUE : IDLE;
                LF_ISSUE: begin
                    if (tx_dv) state <= LF_WAIT;
                    else if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= ASC_LF;
                    end
                end
                LF_WAIT: if (tx_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_hexdump.sv
// Directed bench for rgmii_hexdump: a uart_tx model pops an expected-character
// scoreboard on every tx_dv; stimulus pushes expectations as bytes are driven.
module tb_rgmii_hexdump;
    import rgmii_pkg::*;

    localparam int DEPTH    = 64;
    localparam int BPL      = 16;
    localparam int DONE_DLY = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [6:0]  fifo_level;

    logic        model_busy = 1'b0;
    logic        ext_busy   = 1'b0;
    logic        hold       = 1'b0;
    logic        prev_dv    = 1'b0;
    int          cnt        = 0;
    int          dv_cnt     = 0;
    int          checks     = 0;
    int          errors     = 0;
    int          mcol       = 0;
    logic [7:0]  exp_q[$];

    assign tx_active = model_busy | ext_busy;

    always #5 clk = ~clk;

    rgmii_hexdump #(.FIFO_DEPTH(DEPTH), .BYTES_PER_LINE(BPL)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    task automatic exp_push(input logic [7:0] d, input logic l);
        exp_q.push_back(hx(d[7:4]));
        exp_q.push_back(hx(d[3:0]));
        if (l || mcol == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            mcol = 0;
        end else begin
            exp_q.push_back(8'h20);
            mcol++;
        end
    endtask

    // Drive one byte across one clock edge; leaves in_valid asserted.
    task automatic send(input logic [7:0] d, input logic l, input logic acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (acc) exp_push(d, l);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3 * DONE_DLY) @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // uart_tx model: scoreboard compare on tx_dv, done pulse DONE_DLY later.
    always @(negedge clk) begin
        if (reset) begin
            model_busy = 1'b0;
            tx_done    = 1'b0;
            cnt        = 0;
            prev_dv    = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_dv) begin
                dv_cnt++;
                chk("dv_while_busy", model_busy, 1'b0);
                chk("dv_width", prev_dv, 1'b0);
                chk("char_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("tx_byte", tx_byte, exp_q.pop_front());
                model_busy = 1'b1;
                cnt        = DONE_DLY;
            end else if (model_busy && !hold) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done    = 1'b1;
                    model_busy = 1'b0;
                end
            end
            prev_dv = tx_dv;
        end
    end

    initial begin
        int n;
        int dv0;
        tx_done  = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 16'h0);
        chk("rst_level", fifo_level, 7'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single byte with last: latency 2, then A 5 CR LF.
        dv0 = dv_cnt;
        send(8'hA5, 1'b1, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("latency_e1", tx_dv, 1'b0);
        @(posedge clk); #1;
        chk("latency_e2", tx_dv, 1'b1);
        drain("drain_a5");
        chk("a5_dv_count", dv_cnt - dv0, 4);

        // 17 bytes, line wrap after 0x0F, frame end after 0x10.
        dv0 = dv_cnt;
        for (int i = 0; i < 17; i++) send(8'(i), i == 16, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("drain_17");
        chk("17_dv_count", dv_cnt - dv0, 17 * 3 + 2);

        // uart_tx busy while the high nibble is pending.
        ext_busy = 1'b1;
        dv0 = dv_cnt;
        send(8'h5A, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_dv_while_active", dv_cnt - dv0, 0);
        ext_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("one_dv_after_active", dv_cnt - dv0, 1);
        drain("drain_5a");

        // Stall the renderer mid-character, then fill and overflow the FIFO.
        hold = 1'b1;
        dv0 = dv_cnt;
        send(8'hEE, 1'b0, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (dv_cnt == dv0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("stall_dv_seen", dv_cnt - dv0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("ready_before_64", in_ready, 1'b1);
            send(8'(8'h40 + i), 1'b0, 1'b1);
        end
        chk("ready_after_64", in_ready, 1'b0);
        chk("level_full", fifo_level, 7'd64);
        send(8'hFF, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("ovf_pulse", overflow, 1'b1);
        chk("ovf_drop_cnt", drop_cnt, 16'd1);
        chk("ovf_level", fifo_level, 7'd64);
        @(posedge clk); #1;
        chk("ovf_single", overflow, 1'b0);

        // Push in the same cycle the FSM pops a full FIFO.
        hold = 1'b0;
        n = 0;
        while (dut.state != LOAD && n < 500) begin @(posedge clk); #1; n++; end
        chk("load_reached", dut.state == LOAD, 1'b1);
        send(8'hC3, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("popush_level", fifo_level, 7'd64);
        chk("popush_no_ovf", overflow, 1'b0);
        chk("popush_drop_cnt", drop_cnt, 16'd1);
        drain("drain_full");
        chk("drained_level", fifo_level, 7'd0);

        // Reset while the low nibble is in flight.
        send(8'h77, 1'b0, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (dut.state != LO_WAIT && n < 200) begin @(posedge clk); #1; n++; end
        chk("lo_wait_reached", dut.state == LO_WAIT, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tx_dv", tx_dv, 1'b0);
        chk("mid_rst_level", fifo_level, 7'd0);
        chk("mid_rst_drop_cnt", drop_cnt, 16'd0);
        exp_q.delete();
        mcol  = 0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_quiet", exp_q.size() == 0 && !tx_dv, 1'b1);
        // Wrap must land after the 16th byte if the column restarted at 0.
        for (int i = 0; i < BPL; i++) send(8'(8'h3C + i), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
